// File: rtl/lane_responder.sv
// lane_responder: one LIF neuron lane over an N_SYN-entry weight memory, with init, integrate/fire and STDP update. Optional leak via LIF_LEAK_EN.
module lane_responder #(
    parameter int N_SYN = 16,
    parameter int W_BITS = 8,
    parameter logic [15:0] THRESH = 16'd512,
    parameter logic [W_BITS-1:0] INIT_W = 8'd64,
    parameter logic [W_BITS-1:0] A_PLUS = 8'd4,
    parameter logic [W_BITS-1:0] A_MINUS = 8'd2,
    parameter logic [15:0] LEAK = 16'd8,
    localparam int AW = $clog2(N_SYN)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_init,
    input  logic              i_run,
    input  logic              i_rest_run,
    input  logic              i_stdp_run,
    input  logic              i_cnt_clr,
    input  logic [N_SYN-1:0]  i_spike,
    output logic [AW-1:0]     o_mem_addr,
    output logic              o_mem_we,
    output logic [W_BITS-1:0] o_mem_wdata,
    input  logic [W_BITS-1:0] i_mem_rdata,
    output logic              o_syn_done,
    output logic              o_inh_valid,
    output logic              o_stdp_done,
    output logic              o_fire,
    output logic [15:0]       o_spk_cnt
);
    typedef enum logic [2:0] {IDLE, INIT, INTG, FIRE, STDP_RD, STDP_WR, DONE} state_t;
    state_t state, state_n;
    logic [AW-1:0] addr, rd_idx;
    logic [N_SYN-1:0] pre;
    logic [15:0] pot, pot_entry, pot_acc;
    logic [16:0] sum;
    logic [W_BITS:0] w_inc;
    logic [W_BITS-1:0] w_upd;
    logic rd_v, fin, ok, last, eval, hit, acc;
    logic c_init, c_stdp, c_run, c_rest, c_clr;
    assign ok = state == IDLE || state == DONE;
    assign c_init = ok && i_init;
    assign c_stdp = ok && !i_init && i_stdp_run;
    assign c_run = ok && !i_init && !i_stdp_run && i_run;
    assign c_rest = ok && !i_init && !i_stdp_run && !i_run && i_rest_run;
    assign c_clr = ok && !i_init && !i_stdp_run && !i_run && !i_rest_run && i_cnt_clr;
    assign acc = c_init || c_stdp || c_run || c_rest || c_clr;
    assign last = addr == AW'(N_SYN - 1);
    assign eval = state == FIRE && !rd_v;
    assign hit = eval && pot >= THRESH;
    assign sum = 17'(pot) + 17'(pre[rd_idx] ? i_mem_rdata : '0);
    assign pot_acc = sum[16] ? 16'hFFFF : sum[15:0];
    assign w_inc = {1'b0, i_mem_rdata} + {1'b0, A_PLUS};
    assign w_upd = pre[addr] ? (w_inc[W_BITS] ? '1 : w_inc[W_BITS-1:0])
                             : (i_mem_rdata < A_MINUS ? '0 : i_mem_rdata - A_MINUS);
    assign o_mem_addr = addr;
    assign o_mem_we = state == INIT || state == STDP_WR;
    assign o_mem_wdata = state == INIT ? INIT_W : w_upd;
`ifdef LIF_LEAK_EN
    assign pot_entry = pot > LEAK ? pot - LEAK : '0;
`else
    assign pot_entry = pot;
`endif

    // State register
    always_ff @(posedge clk)
        state <= reset ? IDLE : state_n;

    // Next-state: commands only from IDLE/DONE; FIRE waits for the last read to land
    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE: state_n = c_init ? INIT : c_stdp ? (o_fire ? STDP_RD : DONE)
                                : (c_run || c_rest) ? INTG : c_clr ? IDLE : state;
            INIT:       state_n = last ? IDLE : INIT;
            INTG:       state_n = last ? FIRE : INTG;
            FIRE:       state_n = rd_v ? FIRE : DONE;
            STDP_RD:    state_n = STDP_WR;
            STDP_WR:    state_n = last ? DONE : STDP_RD;
            default:    state_n = IDLE;
        endcase
    end

    // Datapath: address walk, read pipeline, potential, spike counter and status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            addr <= '0;
            rd_idx <= '0;
            rd_v <= 1'b0;
            fin <= 1'b0;
            pre <= '0;
            pot <= '0;
            o_fire <= 1'b0;
            o_spk_cnt <= '0;
            o_syn_done <= 1'b0;
            o_inh_valid <= 1'b0;
            o_stdp_done <= 1'b0;
        end else begin
            rd_v <= state == INTG;
            rd_idx <= addr;
            fin <= (c_stdp && !o_fire) || (state == STDP_WR && last);
            o_syn_done <= state == INIT && last;
            o_inh_valid <= !acc && (o_inh_valid || eval);
            o_stdp_done <= !acc && (o_stdp_done || fin);
            addr <= acc ? '0 : (state == INIT || state == INTG || state == STDP_WR)
                  ? (last ? '0 : addr + 1'b1) : addr;
            pre <= c_run ? i_spike : (c_rest || c_clr) ? '0 : pre;
            pot <= (c_run || c_rest) ? pot_entry : c_clr ? '0 : rd_v ? pot_acc : hit ? '0 : pot;
            o_fire <= c_clr ? 1'b0 : eval ? hit : o_fire;
            o_spk_cnt <= c_clr ? '0 : (hit && o_spk_cnt != 16'hFFFF) ? o_spk_cnt + 16'd1 : o_spk_cnt;
        end
    end
endmodule

// File: tb/tb_lane_responder.sv
// tb_lane_responder: scoreboard bench for lane_responder with a behavioural weight memory
module tb_lane_responder;
    logic clk = 0, reset = 1;
    logic i_init = 0, i_run = 0, i_rest_run = 0, i_stdp_run = 0, i_cnt_clr = 0;
    logic [15:0] i_spike = 0;
    logic [3:0] o_mem_addr;
    logic o_mem_we;
    logic [7:0] o_mem_wdata, i_mem_rdata;
    logic o_syn_done, o_inh_valid, o_stdp_done, o_fire;
    logic [15:0] o_spk_cnt;

    logic [7:0] mem [16];
    logic [7:0] em [16];
    logic tb_we = 0;
    logic [3:0] tb_a = 0;
    logic [7:0] tb_d = 0;
    logic [15:0] q [$];
    logic [15:0] e;
    int n_cmp = 0, n_err = 0;
    logic [15:0] m_pot = 0, m_pre = 0, m_cnt = 0;
    logic m_fire = 0;

    always #5 clk = ~clk;

    lane_responder dut (
        .clk(clk), .reset(reset), .i_init(i_init), .i_run(i_run), .i_rest_run(i_rest_run),
        .i_stdp_run(i_stdp_run), .i_cnt_clr(i_cnt_clr), .i_spike(i_spike),
        .o_mem_addr(o_mem_addr), .o_mem_we(o_mem_we), .o_mem_wdata(o_mem_wdata),
        .i_mem_rdata(i_mem_rdata), .o_syn_done(o_syn_done), .o_inh_valid(o_inh_valid),
        .o_stdp_done(o_stdp_done), .o_fire(o_fire), .o_spk_cnt(o_spk_cnt)
    );

    always @(posedge clk) begin
        i_mem_rdata <= mem[o_mem_addr];
        if (o_mem_we) mem[o_mem_addr] <= o_mem_wdata;
        else if (tb_we) mem[tb_a] <= tb_d;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (o_mem_we) begin
            if (q.size() == 0) check("unexp_wr", {28'd0, o_mem_addr}, 32'hFFFF);
            else begin
                e = q.pop_front();
                check("wr_addr", {28'd0, o_mem_addr}, {24'd0, e[15:8]});
                check("wr_data", {24'd0, o_mem_wdata}, {24'd0, e[7:0]});
            end
        end
    end

    function automatic logic flag(input int sel);
        return sel == 0 ? o_syn_done : sel == 1 ? o_inh_valid : o_stdp_done;
    endfunction

    function automatic logic [7:0] stdp_w(input logic [7:0] w, input logic p);
        return p ? (w > 8'd251 ? 8'd255 : w + 8'd4) : (w < 8'd2 ? 8'd0 : w - 8'd2);
    endfunction

    task automatic poke(input int a, input logic [7:0] d);
        @(negedge clk);
        tb_a = 4'(a); tb_d = d; tb_we = 1;
        @(posedge clk); #1 tb_we = 0;
        em[a] = d;
    endtask

    task automatic cmd(input logic [4:0] c, input logic [15:0] sp);
        @(negedge clk);
        {i_init, i_stdp_run, i_run, i_rest_run, i_cnt_clr} = c;
        i_spike = sp;
        @(posedge clk); #1;
        {i_init, i_stdp_run, i_run, i_rest_run, i_cnt_clr} = 5'b0;
    endtask

    task automatic wait_flag(input string tag, input int sel, input int n0, input int exp);
        int n = n0;
        do begin @(posedge clk); #1; n++; end while (!flag(sel) && n < 200);
        check(tag, n, exp);
    endtask

    task automatic model_run(input logic [15:0] sp, input bit rest);
        logic [16:0] s;
        m_pre = rest ? 16'h0 : sp;
`ifdef LIF_LEAK_EN
        m_pot = m_pot > 16'd8 ? m_pot - 16'd8 : 16'd0;
`endif
        for (int a = 0; a < 16; a++) if (m_pre[a]) begin
            s = {1'b0, m_pot} + {9'd0, em[a]};
            m_pot = s[16] ? 16'hFFFF : s[15:0];
        end
        m_fire = m_pot >= 16'd512;
        if (m_fire) begin m_pot = 0; m_cnt = m_cnt == 16'hFFFF ? m_cnt : m_cnt + 1; end
    endtask

    task automatic push_init();
        for (int a = 0; a < 16; a++) begin q.push_back({8'(a), 8'd64}); em[a] = 8'd64; end
    endtask

    task automatic do_init();
        push_init();
        cmd(5'b10000, 16'h0);
        wait_flag("syn_lat", 0, 0, 16);
        @(posedge clk); #1;
        check("syn_pulse", o_syn_done, 0);
    endtask

    task automatic do_run(input logic [15:0] sp, input bit rest);
        model_run(sp, rest);
        cmd(rest ? 5'b00010 : 5'b00100, sp);
        check("inh_clr", o_inh_valid, 0);
        wait_flag("inh_lat", 1, 0, 18);
        check("fire", o_fire, m_fire);
        check("spk_cnt", o_spk_cnt, m_cnt);
    endtask

    task automatic push_stdp();
        logic [7:0] nw;
        if (m_fire) for (int a = 0; a < 16; a++) begin
            nw = stdp_w(em[a], m_pre[a]);
            q.push_back({8'(a), nw});
            em[a] = nw;
        end
    endtask

    task automatic do_stdp();
        push_stdp();
        cmd(5'b01000, 16'h0);
        check("stdp_clr", o_stdp_done, 0);
        wait_flag("stdp_lat", 2, 0, m_fire ? 33 : 1);
    endtask

    initial begin
        for (int a = 0; a < 16; a++) begin mem[a] = 0; em[a] = 0; end
        i_init = 1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_we", o_mem_we, 0);
        check("rst_syn", o_syn_done, 0);
        check("rst_fire", o_fire, 0);
        check("rst_cnt", o_spk_cnt, 0);
        check("rst_inh", o_inh_valid, 0);
        check("rst_stdp", o_stdp_done, 0);
        i_init = 0; reset = 0;

        do_init();

        model_run(16'h00FF, 0);
        cmd(5'b00100, 16'h00FF);
        check("inh_clr", o_inh_valid, 0);
        cmd(5'b00100, 16'h0000);
        wait_flag("inh_lat_stray", 1, 1, 18);
        check("fire_512", o_fire, 1);
        check("cnt_1", o_spk_cnt, 1);

        do_stdp();
        check("inh_after_stdp", o_inh_valid, 0);
        do_run(16'h0, 1);
        do_stdp();

        poke(0, 8'd254);
        poke(1, 8'd1);
        for (int a = 2; a < 16; a++) poke(a, 8'd100);
        do_run(16'h00FD, 0);
        do_stdp();

        cmd(5'b00001, 16'h0);
        m_pot = 0; m_cnt = 0; m_fire = 0; m_pre = 0;
        check("clr_cnt", o_spk_cnt, 0);
        check("clr_fire", o_fire, 0);

        for (int a = 0; a < 16; a++) poke(a, a == 0 ? 8'd63 : 8'd64);
        do_run(16'h00FF, 0);
        do_run(16'h0, 1);
        do_run(16'h0002, 0);

        push_init();
        cmd(5'b10100, 16'h00FF);
        wait_flag("prio_syn", 0, 0, 16);
        check("prio_inh", o_inh_valid, 0);
        check("prio_cnt", o_spk_cnt, m_cnt);
        push_stdp();
        cmd(5'b01100, 16'h0);
        wait_flag("prio_stdp", 2, 0, m_fire ? 33 : 1);
        check("prio_inh2", o_inh_valid, 0);

        for (int a = 0; a < 16; a++) poke(a, 8'h11);
        for (int a = 0; a < 3; a++) begin q.push_back({8'(a), 8'd64}); em[a] = 8'd64; end
        cmd(5'b10000, 16'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1;
        @(posedge clk); #1 reset = 0;
        m_pot = 0; m_cnt = 0; m_fire = 0; m_pre = 0;
        check("mid_rst_cnt", o_spk_cnt, 0);
        check("mid_rst_fire", o_fire, 0);
        repeat (20) @(posedge clk);
        #1;
        check("mid_rst_syn", o_syn_done, 0);
        check("mid_rst_mem3", mem[3], 8'h11);
        check("mid_rst_mem15", mem[15], 8'h11);

`ifdef LIF_LEAK_EN
        for (int a = 0; a < 16; a++) poke(a, a == 0 ? 8'd5 : 8'd0);
        do_run(16'h0001, 0);
        do_run(16'h0, 1);
        check("leak_fire", o_fire, 0);
`endif

        check("sb_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/lane_responder.md
LANE_RESPONDER -- requirements
Module: lane_responder

Interface
REQ-001 Parameters SHALL be: N_SYN 16 (synapses per lane); W_BITS 8 (weight width); THRESH 16'd512 (fire threshold); INIT_W 8'd64 (init weight); A_PLUS 8'd4 (potentiation step); A_MINUS 8'd2 (depression step); LEAK 16'd8 (leak per timestep).
REQ-002 Ports: clk in 1, rising-edge clock; reset in 1, synchronous active-high reset. One clock; reset is synchronous and active-high.
REQ-003 Command inputs, 1 bit each, one-cycle pulses from the controller: i_init, i_run, i_rest_run, i_stdp_run, i_cnt_clr.
REQ-004 i_spike in N_SYN, presynaptic spike vector for the current timestep.
REQ-005 Memory port: o_mem_addr out $clog2(N_SYN); o_mem_we out 1; o_mem_wdata out W_BITS; i_mem_rdata in W_BITS, valid exactly one cycle after its address.
REQ-006 o_syn_done out 1, init complete; o_inh_valid out 1, timestep complete; o_stdp_done out 1, weight update complete.
REQ-007 o_fire out 1, neuron fired this timestep; o_spk_cnt out 16, fires since last clear.

Function
REQ-008 States: IDLE, INIT, INTG, FIRE, STDP_RD, STDP_WR, DONE.
REQ-009 Commands SHALL be accepted only in IDLE or DONE; in any other state they SHALL be ignored.
REQ-010 Simultaneous commands: priority i_init > i_stdp_run > i_run > i_rest_run > i_cnt_clr; lower-priority commands in the same cycle SHALL be dropped.
REQ-011 Accepting any command SHALL clear o_inh_valid, o_stdp_done and o_syn_done in the next cycle.
REQ-012 INIT: write INIT_W to addresses 0..N_SYN-1, one per cycle. o_syn_done SHALL pulse for exactly one cycle after the last write, then the block returns to IDLE.
REQ-013 i_run SHALL latch i_spike into a pre-trace register and enter INTG. i_rest_run SHALL do the same with an all-zero pre-trace.
REQ-014 INTG: read addresses 0..N_SYN-1 on consecutive cycles. For each returned weight whose pre-trace bit is set, add it zero-extended to a 16-bit potential, saturating at 16'hFFFF.
REQ-015 FIRE: if potential >= THRESH, set o_fire, clear potential to 0 and increment o_spk_cnt (saturating at 16'hFFFF); otherwise clear o_fire and keep the potential.
REQ-016 After FIRE the block SHALL enter DONE. o_inh_valid SHALL rise exactly N_SYN+2 cycles after the edge that sampled i_run or i_rest_run, and stay high until the next accepted command.
REQ-017 i_stdp_run when o_fire=0: the block SHALL skip memory access; o_stdp_done rises 1 cycle later.
REQ-018 i_stdp_run when o_fire=1: for each address, STDP_RD reads and STDP_WR writes.
  - Pre-trace bit set: w+A_PLUS, saturating at 2^W_BITS-1.
  - Pre-trace bit clear: w-A_MINUS, saturating at 0.
  - o_stdp_done rises 2*N_SYN+1 cycles after the sampling edge and stays high until the next accepted command.
REQ-019 i_cnt_clr SHALL zero potential, o_spk_cnt, o_fire and the pre-trace register.
REQ-020 o_mem_we SHALL be high only in INIT and STDP_WR. The address counter SHALL wrap from N_SYN-1 to 0 without overflow into other state.

Reset
REQ-021 reset SHALL force IDLE and zero all outputs, potential, pre-trace and counters on the next edge. reset SHALL override any command pulse in the same cycle.
REQ-022 Reset mid-INIT or mid-STDP SHALL abort immediately with no further writes. Partially written memory is left as is.

Configuration
REQ-023 LIF_LEAK_EN defined: at INTG entry, potential SHALL be reduced by LEAK (saturating at 0) before accumulation.
REQ-024 LIF_LEAK_EN undefined: no leak is applied, and the leak logic is absent.

Verification
REQ-025 reset, i_init -> 16 writes of 8'd64 at addr 0..15; o_syn_done high exactly one cycle.
REQ-026 Weights 64; i_spike=16'h00FF; i_run -> potential 512, o_fire=1, o_spk_cnt=1, o_inh_valid rises 18 cycles later.
REQ-027 Fired lane, pre-trace 16'h00FF, i_stdp_run -> addr 0-7 = 68, addr 8-15 = 62, o_stdp_done rises 33 cycles later.
REQ-028 Weight 8'd254 with pre bit set, and weight 8'd1 with pre bit clear, during STDP -> 255 and 0 respectively.
REQ-029 i_init and i_run in the same cycle -> INIT only. i_run during INTG -> ignored.
REQ-030 LIF_LEAK_EN, potential 5, i_rest_run -> potential 0, o_fire=0.
